// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: 64x64 data memory, branch resolution, load/store counters.
// Optional misalignment checking is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_wb_stage (
  input  logic         clock,
  input  logic         reset,
  input  logic [499:0] PR3,
  output logic [499:0] PR4,
  output logic         PCSrc,
  output logic [63:0]  BranchTarget,
  output logic [15:0]  load_count,
  output logic [15:0]  store_count,
  output logic         mem_err
);

  logic [4:0]  w_rt;
  logic        w_branch;
  logic        w_mem_read;
  logic        w_mem_write;
  logic        w_memto_reg;
  logic        w_reg_write;
  logic [63:0] w_store_data;
  logic        w_zero;
  logic [63:0] w_alu;
  logic [5:0]  w_idx;
  logic        w_misalign;
  logic        w_rd_ok;
  logic        w_wr_ok;
  logic        w_unused_pr3;

  assign w_rt         = PR3[4:0];
  assign w_branch     = PR3[99];
  assign w_mem_read   = PR3[100];
  assign w_mem_write  = PR3[101];
  assign w_memto_reg  = PR3[102];
  assign w_reg_write  = PR3[103];
  assign w_store_data = PR3[231:168];
  assign w_zero       = PR3[360];
  assign w_alu        = PR3[424:361];
  assign w_idx        = w_alu[8:3];
  assign w_unused_pr3 = ^{PR3[98:5], PR3[167:104], PR3[295:232], PR3[499:425]};

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = (w_mem_read | w_mem_write) & (w_alu[2:0] != 3'b000);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_rd_ok = w_mem_read & ~w_misalign;
  assign w_wr_ok = w_mem_write & ~w_misalign;

  assign PCSrc        = w_branch & w_zero;
  assign BranchTarget = PR3[359:296];

  logic [63:0] r_mem [64];
  logic [4:0]  r_rt;
  logic [63:0] r_alu;
  logic [63:0] r_load;
  logic        r_memto_reg;
  logic        r_reg_write;
  logic [15:0] r_load_count;
  logic [15:0] r_store_count;
  logic        r_mem_err;

  // Memory is never cleared; writes are blocked on any edge seen with reset high.
  always_ff @(posedge clock) begin
    if (!reset && w_wr_ok) begin
      r_mem[w_idx] <= w_store_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rt          <= '0;
      r_alu         <= '0;
      r_load        <= '0;
      r_memto_reg   <= 1'b0;
      r_reg_write   <= 1'b0;
      r_load_count  <= '0;
      r_store_count <= '0;
      r_mem_err     <= 1'b0;
    end else begin
      r_rt        <= w_rt;
      r_alu       <= w_alu;
      r_memto_reg <= w_memto_reg;
      r_reg_write <= w_reg_write;
      // Non-blocking read returns pre-write contents on a same-address read/write.
      r_load      <= w_rd_ok ? r_mem[w_idx] : '0;
      if (w_rd_ok && r_load_count != 16'hFFFF) begin
        r_load_count <= r_load_count + 16'd1;
      end
      if (w_wr_ok && r_store_count != 16'hFFFF) begin
        r_store_count <= r_store_count + 16'd1;
      end
      if (w_misalign) begin
        r_mem_err <= 1'b1;
      end
    end
  end

  assign PR4         = {365'b0, r_reg_write, r_memto_reg, r_load, r_alu, r_rt};
  assign load_count  = r_load_count;
  assign store_count = r_store_count;
  assign mem_err     = r_mem_err;

endmodule
